cla_adder_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.

---
 rtl/cla_pkg.sv | 34 +++
 rtl/cla_group.sv | 45 ++++
 rtl/cla_adder_pipe.sv | 181 ++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : cla_pkg
// | Brief    : Shared bit/group propagate-generate helpers for the pipelined CLA.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
package cla_pkg;

  // Widest second-level lookahead supported (number of groups).
  localparam int MAX_GRP = 32;

  // Returns {p, g} for a single bit pair.
  function automatic logic [1:0] pg_bit(input logic a, input logic b);
    return {a ^ b, a & b};
  endfunction

  // Group carries from group P/G; result bit k is the carry into group k,
  // result bit n is the carry out of group n-1.
  function automatic logic [MAX_GRP:0] lookahead(
    input logic [MAX_GRP-1:0] grp_p,
    input logic [MAX_GRP-1:0] grp_g,
    input logic               cin
  );
    logic [MAX_GRP:0] c;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < MAX_GRP; i++) begin
      c[i+1] = grp_g[i] | (grp_p[i] & c[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : cla_group
// | Brief    : GROUP-bit lookahead cell: group P/G and flat per-bit carries.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_p,
  input  logic [GROUP-1:0] i_g,
  input  logic             i_cin,
  output logic             o_grp_p,
  output logic             o_grp_g,
  output logic [GROUP-1:0] o_carry
);

  // w_gen[i]: carry generated inside bits [i-1:0]; w_prop[i]: those bits all propagate.
  logic [GROUP:0] w_gen;
  logic [GROUP:0] w_prop;

  for (genvar i = 0; i <= GROUP; i++) begin : g_carry
    if (i == 0) begin : g_base
      assign w_gen[i]  = 1'b0;
      assign w_prop[i] = 1'b1;
    end else begin : g_terms
      logic [i-1:0] w_terms;
      for (genvar j = 0; j < i; j++) begin : g_term
        if (j == i - 1) begin : g_top
          assign w_terms[j] = i_g[j];
        end else begin : g_chain
          assign w_terms[j] = i_g[j] & (&i_p[i-1:j+1]);
        end
      end
      assign w_gen[i]  = |w_terms;
      assign w_prop[i] = &i_p[i-1:0];
    end
  end

  assign o_carry = w_gen[GROUP-1:0] | (w_prop[GROUP-1:0] & {GROUP{i_cin}});
  assign o_grp_g = w_gen[GROUP];
  assign o_grp_p = w_prop[GROUP];

endmodule
`default_nettype wire

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : cla_adder_pipe
// | Brief    : 3-stage pipelined carry-lookahead adder/subtractor, valid/ready.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NGRP = WIDTH / GROUP;

  if (((WIDTH % GROUP) != 0) || (GROUP < 2) || (GROUP > 8) || (NGRP >= MAX_GRP)) begin : g_bad_params
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP and GROUP must be 2..8");
  end

  // ---------------------------------------------------------------- handshake
  logic r_v1;
  logic r_v2;
  logic r_v3;
  logic w_adv1;
  logic w_adv2;
  logic w_adv3;

  // An empty stage always accepts, so bubbles collapse under backpressure.
  assign w_adv3    = ~r_v3 | out_ready;
  assign w_adv2    = ~r_v2 | w_adv3;
  assign w_adv1    = ~r_v1 | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v3;

  // ---------------------------------------------------------------- stage 1
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_c0;
  logic [WIDTH-1:0] r_p1;
  logic [WIDTH-1:0] r_g1;
  logic             r_c01;

  assign w_b  = in_b ^ {WIDTH{in_sub}};
  assign w_c0 = in_sub | in_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {w_p[i], w_g[i]} = pg_bit(in_a[i], w_b[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_p1  <= '0;
      r_g1  <= '0;
      r_c01 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p1  <= w_p;
        r_g1  <= w_g;
        r_c01 <= w_c0;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [NGRP-1:0]    w_gp;
  logic [NGRP-1:0]    w_gg;
  logic [WIDTH-1:0]   w_s2_carry_unused;
  logic [MAX_GRP-1:0] w_gp_ext;
  logic [MAX_GRP-1:0] w_gg_ext;
  logic [MAX_GRP:0]   w_la;
  logic               w_la_unused;
  logic [NGRP:0]      w_gc;
  logic [WIDTH-1:0]   r_p2;
  logic [WIDTH-1:0]   r_g2;
  logic [NGRP:0]      r_gc2;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp_pg
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_p     (r_p1[k*GROUP +: GROUP]),
      .i_g     (r_g1[k*GROUP +: GROUP]),
      .i_cin   (1'b0),
      .o_grp_p (w_gp[k]),
      .o_grp_g (w_gg[k]),
      .o_carry (w_s2_carry_unused[k*GROUP +: GROUP])
    );
  end

  always_comb begin
    w_gp_ext           = '0;
    w_gg_ext           = '0;
    w_gp_ext[NGRP-1:0] = w_gp;
    w_gg_ext[NGRP-1:0] = w_gg;
  end

  assign w_la        = lookahead(w_gp_ext, w_gg_ext, r_c01);
  assign w_gc        = w_la[NGRP:0];
  assign w_la_unused = ^w_la[MAX_GRP:NGRP+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_p2  <= '0;
      r_g2  <= '0;
      r_gc2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p2  <= r_p1;
        r_g2  <= r_g1;
        r_gc2 <= w_gc;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [WIDTH-1:0] w_carry;
  logic [NGRP-1:0]  w_s3_gp_unused;
  logic [NGRP-1:0]  w_s3_gg_unused;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] r_sum3;
  logic             r_cout3;
  logic             r_ovf3;

  // Same group cells, now seeded with the registered group carries.
  for (genvar k = 0; k < NGRP; k++) begin : g_grp_sum
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_p     (r_p2[k*GROUP +: GROUP]),
      .i_g     (r_g2[k*GROUP +: GROUP]),
      .i_cin   (r_gc2[k]),
      .o_grp_p (w_s3_gp_unused[k]),
      .o_grp_g (w_s3_gg_unused[k]),
      .o_carry (w_carry[k*GROUP +: GROUP])
    );
  end

  assign w_sum  = r_p2 ^ w_carry;
  assign w_cout = r_gc2[NGRP];
  assign w_ovf  = w_carry[WIDTH-1] ^ w_cout;

  // Result registers load only with a valid beat, so out_* hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_sum3  <= '0;
      r_cout3 <= 1'b0;
      r_ovf3  <= 1'b0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_sum3  <= w_sum;
        r_cout3 <= w_cout;
        r_ovf3  <= w_ovf;
      end
    end
  end

  assign out_sum  = r_sum3;
  assign out_cout = r_cout3;
  assign out_ovf  = r_ovf3;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : tb_cla_adder_pipe
// | Brief    : Scoreboard bench for the pipelined CLA adder/subtractor.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_cla_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;

  logic [W+1:0] sb[$];

  logic         s_in_ready;
  logic         s_in_fire;
  logic         s_out_valid;
  logic         s_out_fire;
  logic [W-1:0] s_sum;
  logic         s_cout;
  logic         s_ovf;

  cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Reference result packed as {sum, cout, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {r[W-1:0], r[W], ovf};
  endfunction

  // One clock: drive at posedge+1, observe at negedge, push accepted beats.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input logic ordy);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_in_fire   = iv && in_ready;
    s_out_valid = out_valid;
    s_out_fire  = out_valid && ordy;
    s_sum       = out_sum;
    s_cout      = out_cout;
    s_ovf       = out_ovf;
    if (s_in_fire) sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
  endtask

  // Send one beat on an idle pipe; lat = cycles from accept to output, -1 on timeout.
  task automatic send_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, output int lat);
    int n;
    lat = -1;
    n   = 0;
    do begin
      step(1'b1, a, b, cin, sub, 1'b1);
      n++;
    end while (!s_in_fire && n < 10);
    if (s_in_fire) begin
      for (int k = 1; k <= 10; k++) begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        if (s_out_fire) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b sum=%h cout=%b ovf=%b, required 0/0000/0/0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h1000 + i), 16'h0101, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || sb.size() != 3) begin
      errors++;
      $display("FAIL reset_fill: out_valid=%b queued=%0d, required 1 and 3", out_valid, sb.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b sum=%h, required 0 and 0000", out_valid, out_sum);
    end
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (s_out_valid !== 1'b0 || s_sum !== '0) begin
        errors++;
        $display("FAIL reset_stale: cycle %0d out_valid=%b sum=%h, required 0 and 0000", i, s_out_valid, s_sum);
      end
    end
  endtask

  task automatic test_add();
    int           lat;
    logic [W+1:0] exp;
    logic [W+1:0] req [3];
    logic [W-1:0] va  [3];
    logic [W-1:0] vb  [3];
    logic         vc  [3];
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; req[0] = {16'h0000, 1'b1, 1'b0};
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0; req[1] = {16'h8000, 1'b0, 1'b1};
    va[2] = 16'h1234; vb[2] = 16'h4321; vc[2] = 1'b1; req[2] = {16'h5556, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_and_wait(va[i], vb[i], vc[i], 1'b0, lat);
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL add_latency[%0d]: got %0d cycles required 3", i, lat);
      end
      if (lat > 0) begin
        exp = sb.pop_front();
        checks++;
        if ({s_sum, s_cout, s_ovf} !== exp || exp !== req[i]) begin
          errors++;
          $display("FAIL add_result[%0d]: got sum=%h cout=%b ovf=%b required %h", i, s_sum, s_cout, s_ovf, req[i]);
        end
      end else begin
        sb.delete();
      end
    end
  endtask

  task automatic test_sub();
    int           lat;
    logic [W+1:0] exp;
    logic [W+1:0] req [2];
    logic [W-1:0] va  [2];
    logic [W-1:0] vb  [2];
    va[0] = 16'h8000; vb[0] = 16'h0001; req[0] = {16'h7FFF, 1'b1, 1'b1};
    va[1] = 16'h0005; vb[1] = 16'h0007; req[1] = {16'hFFFE, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      // in_cin is driven high to show it is ignored in subtract mode.
      send_and_wait(va[i], vb[i], 1'b1, 1'b1, lat);
      if (lat > 0) begin
        exp = sb.pop_front();
        checks++;
        if ({s_sum, s_cout, s_ovf} !== exp || exp !== req[i]) begin
          errors++;
          $display("FAIL sub_result[%0d]: got sum=%h cout=%b ovf=%b required %h", i, s_sum, s_cout, s_ovf, req[i]);
        end
      end else begin
        sb.delete();
        checks++;
        errors++;
        $display("FAIL sub_timeout[%0d]: no result, required one within 10 cycles", i);
      end
    end
  endtask

  task automatic test_backpressure();
    int           sent = 0;
    int           got  = 0;
    logic [W+1:0] exp;
    logic         ordy;
    logic         exp_rdy;
    logic         pv = 1'b0;
    logic         pr = 1'b1;
    logic [W+1:0] pdat = '0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      ordy    = !(cyc >= 4 && cyc < 9);
      exp_rdy = !(sb.size() == 3 && !ordy);
      step(sent < 10, W'(sent * 16'h1357 + 16'h00F0), W'(sent * 16'h0321 + 16'h8001),
           1'b0, sent[0], ordy);
      checks++;
      if (s_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready: cycle %0d got %b required %b", cyc, s_in_ready, exp_rdy);
      end
      if (pv && !pr) begin
        checks++;
        if (s_out_valid !== 1'b1 || {s_sum, s_cout, s_ovf} !== pdat) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d got valid=%b data=%h required 1/%h", cyc, s_out_valid,
                   {s_sum, s_cout, s_ovf}, pdat);
        end
      end
      if (s_in_fire) sent++;
      if (s_out_fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: unexpected output sum=%h", s_sum);
        end else begin
          exp = sb.pop_front();
          if ({s_sum, s_cout, s_ovf} !== exp) begin
            errors++;
            $display("FAIL bp_data: beat %0d got %h required %h", got, {s_sum, s_cout, s_ovf}, exp);
          end
        end
        got++;
      end
      pv   = s_out_valid;
      pr   = ordy;
      pdat = {s_sum, s_cout, s_ovf};
    end
    checks++;
    if (got != 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d results (%0d pending) required 10 (0)", got, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int           sent = 0;
    logic [W+1:0] exp;
    logic         exp_fire;
    for (int n = 0; n < 110; n++) begin
      step(sent < 100, W'(n * 16'h0B3D), W'(16'hFFFF - n * 16'h0071), n[2], n[1], 1'b1);
      if (sent < 100) begin
        checks++;
        if (s_in_fire !== 1'b1) begin
          errors++;
          $display("FAIL b2b_accept: cycle %0d in_ready=%b required 1", n, s_in_ready);
        end
      end
      if (s_in_fire) sent++;
      exp_fire = (n >= 3 && n < 103);
      checks++;
      if (s_out_fire !== exp_fire) begin
        errors++;
        $display("FAIL b2b_timing: cycle %0d out_valid=%b required %b", n, s_out_valid, exp_fire);
      end
      if (s_out_fire && sb.size() != 0) begin
        exp = sb.pop_front();
        checks++;
        if ({s_sum, s_cout, s_ovf} !== exp) begin
          errors++;
          $display("FAIL b2b_data: cycle %0d got %h required %h", n, {s_sum, s_cout, s_ovf}, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d results missing, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_random();
    int           sent = 0;
    int           cyc  = 0;
    logic         have = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         ordy;
    logic         exp_rdy;
    logic [W+1:0] exp;
    while ((sent < 3000 || sb.size() != 0) && cyc < 20000) begin
      if (!have && sent < 3000) begin
        have = ($urandom_range(0, 3) != 0);
        a    = W'($urandom());
        b    = W'($urandom());
        cin  = 1'($urandom());
        sub  = 1'($urandom());
      end
      ordy    = (sent >= 3000) || ($urandom_range(0, 9) < 7);
      exp_rdy = !(sb.size() == 3 && !ordy);
      step(have, a, b, cin, sub, ordy);
      cyc++;
      checks++;
      if (s_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_in_ready: cycle %0d got %b required %b", cyc, s_in_ready, exp_rdy);
      end
      if (s_in_fire) begin
        have = 1'b0;
        sent++;
      end
      if (s_out_fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: unexpected output sum=%h", s_sum);
        end else begin
          exp = sb.pop_front();
          if ({s_sum, s_cout, s_ovf} !== exp) begin
            errors++;
            $display("FAIL rnd_data: cycle %0d got %h required %h", cyc, {s_sum, s_cout, s_ovf}, exp);
          end
        end
      end
    end
    checks++;
    if (sent != 3000 || sb.size() != 0) begin
      errors++;
      $display("FAIL rnd_complete: sent %0d pending %0d, required 3000 and 0", sent, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
